crcu_domain_seq_ctrl: RTL and testbench

- Sequencer for the per-domain clock gates and resets of the CRCU domains: SPU, VPU, CPM, LD, WI_IOL, TAP, DB_UNIT, VP_DEBUG (indices 0..7).
- Takes one bring-up or shut-down request at a time over a valid/ready handshake.
- Walks the requested domains in index order, using fixed clock-settle and reset-hold delays.
- Drives the clock-enable and reset inputs of the clock/reset management block.

---
 rtl/crcu_domain_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_crcu_domain_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crcu_domain_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// crcu_domain_seq_ctrl - walks CRCU domains in index order, stepping clock gate and reset
// with fixed settle/hold delays. Define CRCU_SEQ_ACK_EN for dom_ack wait with timeout/err. Rev 1.0
// ---------------------------------------------------------------------------
module crcu_domain_seq_ctrl #(
  parameter int N_DOM       = 8,
  parameter int CLK_SETTLE  = 4,
  parameter int RST_HOLD    = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             CRCU_CLK,
  input  logic             CRCU_RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [N_DOM-1:0] req_mask,
`ifdef CRCU_SEQ_ACK_EN
  input  logic [N_DOM-1:0] dom_ack,
  output logic [N_DOM-1:0] err,
`endif
  output logic [N_DOM-1:0] dom_clk_en,
  output logic [N_DOM-1:0] dom_rst_n,
  output logic [N_DOM-1:0] dom_on,
  output logic             busy,
  output logic             done
);

  localparam int CNT_MAX = (CLK_SETTLE > RST_HOLD)
                         ? ((CLK_SETTLE > ACK_TIMEOUT) ? CLK_SETTLE : ACK_TIMEOUT)
                         : ((RST_HOLD > ACK_TIMEOUT) ? RST_HOLD : ACK_TIMEOUT);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int IDX_W = $clog2(N_DOM + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(CLK_SETTLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(N_DOM);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ACT1  = 3'd2,
    WAIT1 = 3'd3,
    ACT2  = 3'd4,
    WAIT2 = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t           state;
  logic             op;
  logic [N_DOM-1:0] mask;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [N_DOM-1:0] sel;
  logic             at_target;
`ifdef CRCU_SEQ_ACK_EN
  localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(ACK_TIMEOUT - 1);
  logic             ack_wait;
`endif

  // One-hot of the current domain; all-zero once idx runs past the last domain.
  assign sel       = {{(N_DOM-1){1'b0}}, 1'b1} << idx;
  assign at_target = op ? ((dom_clk_en & dom_rst_n & sel) == sel)
                        : (((dom_clk_en | dom_rst_n) & sel) == '0);
  assign dom_on    = dom_clk_en & dom_rst_n;

  always_ff @(posedge CRCU_CLK) begin
    if (!CRCU_RST) begin
      state      <= IDLE;
      op         <= 1'b0;
      mask       <= '0;
      idx        <= '0;
      cnt        <= '0;
      dom_clk_en <= '0;
      dom_rst_n  <= '0;
      req_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef CRCU_SEQ_ACK_EN
      ack_wait   <= 1'b0;
      err        <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            op        <= req_op;
            mask      <= req_mask;
            idx       <= '0;
            state     <= SCAN;
`ifdef CRCU_SEQ_ACK_EN
            err       <= '0;
`endif
          end
        end
        SCAN: begin
          if (idx == IDX_END)                         state <= DONE;
          else if (((mask & sel) != '0) && !at_target) state <= ACT1;
          else                                         idx   <= idx + IDX_W'(1);
        end
        // Bring-up ungates the clock first; shut-down asserts reset first.
        ACT1: begin
          if (op) begin
            dom_clk_en <= dom_clk_en | sel;
            cnt        <= SETTLE_LD;
          end else begin
            dom_rst_n  <= dom_rst_n & ~sel;
            cnt        <= HOLD_LD;
          end
          state <= WAIT1;
        end
        WAIT1: begin
          if (cnt == '0) state <= ACT2;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ACT2: begin
          if (op) begin
            dom_rst_n  <= dom_rst_n | sel;
            cnt        <= HOLD_LD;
          end else begin
            dom_clk_en <= dom_clk_en & ~sel;
            cnt        <= SETTLE_LD;
          end
          state <= WAIT2;
        end
        WAIT2: begin
`ifdef CRCU_SEQ_ACK_EN
          if (ack_wait) begin
            if ((dom_ack & sel) != '0) begin
              ack_wait <= 1'b0;
              idx      <= idx + IDX_W'(1);
              state    <= SCAN;
            end else if (cnt == '0) begin
              // Domain never acknowledged: back it out and abandon the rest.
              ack_wait   <= 1'b0;
              err        <= err | sel;
              dom_rst_n  <= dom_rst_n & ~sel;
              dom_clk_en <= dom_clk_en & ~sel;
              state      <= DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!op || ((dom_ack & sel) != '0)) begin
            idx   <= idx + IDX_W'(1);
            state <= SCAN;
          end else begin
            ack_wait <= 1'b1;
            cnt      <= ACK_LD;
          end
`else
          if (cnt == '0) begin
            idx   <= idx + IDX_W'(1);
            state <= SCAN;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
`endif
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_crcu_domain_seq_ctrl.sv
`default_nettype none
// tb_crcu_domain_seq_ctrl - table, hand-written and random checks against an event-schedule model.
module tb_crcu_domain_seq_ctrl;

  localparam int N_DOM       = 8;
  localparam int CLK_SETTLE  = 4;
  localparam int RST_HOLD    = 2;
  localparam int ACK_TIMEOUT = 16;
  localparam int STEP        = 2 + CLK_SETTLE + RST_HOLD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_op = 1'b0;
  logic [7:0] req_mask = '0;
  logic [7:0] dom_clk_en, dom_rst_n, dom_on;
  logic       busy, done;
`ifdef CRCU_SEQ_ACK_EN
  logic [7:0] dom_ack = 8'hFF;
  logic [7:0] err;
`endif

  crcu_domain_seq_ctrl #(
    .N_DOM(N_DOM), .CLK_SETTLE(CLK_SETTLE), .RST_HOLD(RST_HOLD), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CRCU_CLK  (clk),
    .CRCU_RST  (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_mask  (req_mask),
`ifdef CRCU_SEQ_ACK_EN
    .dom_ack   (dom_ack),
    .err       (err),
`endif
    .dom_clk_en(dom_clk_en),
    .dom_rst_n (dom_rst_n),
    .dom_on    (dom_on),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: present domain state plus, per request, the cycle each output changes.
  logic [7:0] m_clk = '0;
  logic [7:0] m_rst = '0;
  int         ev_clk_t [8];
  int         ev_rst_t [8];

  typedef struct {
    logic       op;
    logic [7:0] mask;
    logic [7:0] exp_on;
    int         exp_k;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the accepting edge; returns the cycle of the done pulse.
  function automatic int plan(input logic op, input logic [7:0] mask);
    int s = 0;
    int d1 = op ? CLK_SETTLE : RST_HOLD;
    int d2 = op ? RST_HOLD : CLK_SETTLE;
    for (int d = 0; d < 8; d++) begin
      s++;
      ev_clk_t[d] = -1;
      ev_rst_t[d] = -1;
      if (mask[d] && !(op ? (m_clk[d] && m_rst[d]) : (!m_clk[d] && !m_rst[d]))) begin
        if (op) begin ev_clk_t[d] = s + 1; ev_rst_t[d] = s + 2 + d1; end
        else    begin ev_rst_t[d] = s + 1; ev_clk_t[d] = s + 2 + d1; end
        s = s + 2 + d1 + d2;
      end
    end
    return s + 2;
  endfunction

  task automatic apply_plan(input logic op);
    for (int d = 0; d < 8; d++) begin
      if (ev_clk_t[d] >= 0) m_clk[d] = op;
      if (ev_rst_t[d] >= 0) m_rst[d] = op;
    end
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 50) begin tick(); w++; end
    check("ready_before_request", req_ready, 1'b1);
  endtask

  task automatic run_req(input logic op, input logic [7:0] mask, output int lat);
    int tdone;
    logic [7:0] ec, er;
    wait_ready();
    tdone = plan(op, mask);
    req_valid = 1'b1; req_op = op; req_mask = mask;
    tick();
    req_valid = 1'b0;
    lat = -1;
    for (int t = 0; t <= tdone + 1; t++) begin
      for (int d = 0; d < 8; d++) begin
        ec[d] = (ev_clk_t[d] >= 0 && t >= ev_clk_t[d]) ? op : m_clk[d];
        er[d] = (ev_rst_t[d] >= 0 && t >= ev_rst_t[d]) ? op : m_rst[d];
      end
      check($sformatf("seq op=%0d mask=%02h t=%0d {clk,rst,on,busy,done,ready}", op, mask, t),
            {dom_clk_en, dom_rst_n, dom_on, busy, done, req_ready},
            {ec, er, ec & er, (t < tdone), (t == tdone), (t > tdone)});
      if (done && lat < 0) lat = t;
      if (t <= tdone) tick();
    end
    apply_plan(op);
  endtask

  initial begin
    int lat;
    int tdone;
    int c;
    bit held_ok;

    tbl[0] = '{1'b1, 8'h01, 8'h01, 1};
    tbl[1] = '{1'b1, 8'h81, 8'h81, 1};
    tbl[2] = '{1'b0, 8'hFF, 8'h00, 2};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 0};
    tbl[4] = '{1'b1, 8'h3C, 8'h3C, 4};
    tbl[5] = '{1'b1, 8'hFF, 8'hFF, 4};
    tbl[6] = '{1'b0, 8'h0F, 8'hF0, 4};
    tbl[7] = '{1'b0, 8'h0F, 8'hF0, 0};

    // Reset held low for three edges, then released.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_outputs_%0d", i),
            {dom_clk_en, dom_rst_n, busy, done, req_ready}, '0);
    end
    rst_n = 1'b1;
    check("ready_low_at_release", req_ready, 1'b0);
    tick();
    check("ready_one_cycle_after_release", req_ready, 1'b1);
    check("outputs_idle_after_release", {dom_clk_en, dom_rst_n, busy, done}, '0);

    // Directed table: final state and acceptance-to-done latency.
    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].op, tbl[i].mask, lat);
      check($sformatf("tbl%0d_dom_on", i), dom_on, tbl[i].exp_on);
      check($sformatf("tbl%0d_latency", i), lat, N_DOM + 2 + tbl[i].exp_k * STEP);
    end

    run_req(1'b0, 8'hFF, lat);

    // Reset during WAIT1 of domain 3 aborts with no done pulse.
    wait_ready();
    req_valid = 1'b1; req_op = 1'b1; req_mask = 8'h08;
    tick();
    req_valid = 1'b0;
    for (int t = 1; t <= 6; t++) tick();
    check("wait1_dom3_clk_on", dom_clk_en, 8'h08);
    rst_n = 1'b0;
    tick();
    check("abort_all_zero", {dom_clk_en, dom_rst_n, busy, done, req_ready}, '0);
    tick();
    check("abort_no_done", {done, busy}, '0);
    rst_n = 1'b1;
    tick();
    check("abort_ready_after_release", {req_ready, done, dom_clk_en}, {1'b1, 1'b0, 8'h00});
    m_clk = '0;
    m_rst = '0;

    // Second request held while busy; mask=0 request follows.
    wait_ready();
    tdone = plan(1'b1, 8'h02);
    req_valid = 1'b1; req_op = 1'b1; req_mask = 8'h02;
    tick();
    req_op = 1'b0; req_mask = 8'h00;
    held_ok = 1'b1;
    for (int t = 1; t <= tdone; t++) begin
      tick();
      if (req_ready) held_ok = 1'b0;
    end
    check("ready_low_while_busy", held_ok, 1'b1);
    tick();
    check("ready_after_done", req_ready, 1'b1);
    apply_plan(1'b1);
    tick();
    req_valid = 1'b0;
    check("second_accepted", {busy, req_ready}, {1'b1, 1'b0});
    lat = -1;
    for (c = 1; c <= 40; c++) begin
      tick();
      if (done) begin lat = c; break; end
    end
    check("mask0_done_latency", lat, N_DOM + 2);
    check("mask0_dom_on", dom_on, 8'h02);

    // Randomized requests against the model.
    for (int i = 0; i < 20; i++) begin
      logic rop;
      logic [7:0] rmask;
      rop   = 1'($urandom_range(0, 1));
      rmask = 8'($urandom);
      run_req(rop, rmask, lat);
    end

`ifdef CRCU_SEQ_ACK_EN
    run_req(1'b0, 8'hFF, lat);
    dom_ack = 8'hFB;
    wait_ready();
    req_valid = 1'b1; req_op = 1'b1; req_mask = 8'h0C;
    tick();
    req_valid = 1'b0;
    begin
      int  ndone = 0;
      bit  saw_clk2 = 1'b0;
      for (int t = 0; t < 60; t++) begin
        tick();
        if (done) ndone++;
        if (dom_clk_en[2]) saw_clk2 = 1'b1;
      end
      check("ack_done_once", ndone, 1);
      check("ack_dom2_was_clocked", saw_clk2, 1'b1);
      check("ack_err", err, 8'h04);
      check("ack_dom_state", {dom_clk_en, dom_rst_n}, '0);
    end
    dom_ack = 8'hFF;
    m_clk = '0;
    m_rst = '0;
    run_req(1'b0, 8'h00, lat);
    check("err_cleared_on_accept", err, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
